// File: rtl/cache_pkg.sv
// Shared widths and FSM encoding for the cache-to-DRAM line adaptor.
package cache_pkg;
    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(BEATS);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } adaptor_state_e;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side pmem bus plus DRAM-side burst bus seen by the adaptor.
interface cacheline_adaptor_if;
    import cache_pkg::*;

    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_WIDTH-1:0]  pmem_address;
    logic [LINE_WIDTH-1:0]  pmem_wdata_256;
    logic [LINE_WIDTH-1:0]  pmem_rdata_256;
    logic                   pmem_resp;
    logic                   burst_read;
    logic                   burst_write;
    logic [ADDR_WIDTH-1:0]  burst_address;
    logic [BURST_WIDTH-1:0] burst_wdata;
    logic [BURST_WIDTH-1:0] burst_rdata;
    logic                   burst_resp;

    // slave = the adaptor; master = the cache controller and DRAM model around it
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata_256, burst_rdata, burst_resp,
        output pmem_rdata_256, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata_256, burst_rdata, burst_resp,
        input  pmem_rdata_256, pmem_resp, burst_read, burst_write, burst_address, burst_wdata
    );
endinterface

// File: rtl/burst_line_buffer.sv
// One cache line of storage with beat-indexed write/read and a whole-line load.
module burst_line_buffer
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LINE_WIDTH-1:0]  line_in,
    input  logic                   we,
    input  logic [CNT_W-1:0]       idx,
    input  logic [BURST_WIDTH-1:0] din,
    output logic [LINE_WIDTH-1:0]  line_out,
    output logic [BURST_WIDTH-1:0] beat_out
);
    logic [LINE_WIDTH-1:0] line;

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (load) begin
            line <= line_in;
        end else if (we) begin
            line[int'(idx)*BURST_WIDTH +: BURST_WIDTH] <= din;
        end
    end

    assign line_out = line;
    assign beat_out = line[int'(idx)*BURST_WIDTH +: BURST_WIDTH];
endmodule

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit pmem line request into a 4-beat 64-bit DRAM burst and pulses pmem_resp when done.
module cacheline_adaptor
    import cache_pkg::*;
(
    input logic                clk,
    input logic                rst,
    cacheline_adaptor_if.slave bus
);
    adaptor_state_e         state, next_state;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   accept;
    logic                   beat_done;
    logic                   rd_we;
    logic                   wr_load;
    logic [BURST_WIDTH-1:0] wr_beat;
    logic [BURST_WIDTH-1:0] rd_beat_unused;
    logic [LINE_WIDTH-1:0]  wr_line_unused;

    assign accept    = (state == IDLE) && (bus.pmem_read || bus.pmem_write);
    assign beat_done = ((state == READ_BURST) || (state == WRITE_BURST)) && bus.burst_resp;
    assign rd_we     = (state == READ_BURST) && bus.burst_resp;
    // Read has priority, so the write line is only captured when no read is pending.
    assign wr_load   = (state == IDLE) && !bus.pmem_read && bus.pmem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= next_state;
            if (accept)    addr <= bus.pmem_address & ~OFFSET_MASK;
            if (beat_done) cnt  <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.pmem_read)       next_state = READ_BURST;
                else if (bus.pmem_write) next_state = WRITE_BURST;
            end
            READ_BURST, WRITE_BURST: begin
                if (bus.burst_resp && (cnt == LAST_BEAT)) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.burst_read    = (state == READ_BURST);
        bus.burst_write   = (state == WRITE_BURST);
        bus.pmem_resp     = (state == DONE);
        bus.burst_address = addr;
        bus.burst_wdata   = (state == WRITE_BURST) ? wr_beat : '0;
    end

    // Separate read and write lines so the returned read line survives intervening writes.
    burst_line_buffer rd_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .line_in  ('0),
        .we       (rd_we),
        .idx      (cnt),
        .din      (bus.burst_rdata),
        .line_out (bus.pmem_rdata_256),
        .beat_out (rd_beat_unused)
    );

    burst_line_buffer wr_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load),
        .line_in  (bus.pmem_wdata_256),
        .we       (1'b0),
        .idx      (cnt),
        .din      ('0),
        .line_out (wr_line_unused),
        .beat_out (wr_beat)
    );

    cover property (@(posedge clk) disable iff (rst)
        (state == IDLE) && bus.pmem_read && bus.pmem_write);
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, stalled writes, priority, back-to-back, reset abort.
module tb_cacheline_adaptor;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [255:0] rdata_exp);
        chk({tag, "_resp"},   256'(bus.pmem_resp),     256'(0));
        chk({tag, "_bread"},  256'(bus.burst_read),    256'(0));
        chk({tag, "_bwrite"}, 256'(bus.burst_write),   256'(0));
        chk({tag, "_wdata"},  256'(bus.burst_wdata),   256'(0));
        chk({tag, "_rdata"},  bus.pmem_rdata_256,      rdata_exp);
    endtask

    // Zero-stall read burst starting from the cycle after acceptance; ends in DONE.
    task automatic read_beats(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_bread_on"}, 256'(bus.burst_read),  256'(1));
            chk({tag, "_no_bw"},    256'(bus.burst_write), 256'(0));
            chk({tag, "_no_resp"},  256'(bus.pmem_resp),   256'(0));
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = beats[i];
            tick();
        end
        bus.burst_resp  = 1'b0;
        bus.burst_rdata = '0;
    endtask

    logic [63:0]  s [4];
    logic [255:0] wline;
    logic [6:0]   resp_pat;
    int           slice_pat [7];

    initial begin
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.pmem_address   = '0;
        bus.pmem_wdata_256 = '0;
        bus.burst_rdata    = '0;
        bus.burst_resp     = 1'b0;

        // Reset state
        tick(); tick();
        chk_idle_outputs("reset", 256'(0));
        chk("reset_baddr", 256'(bus.burst_address), 256'(0));
        rst = 1'b0;
        tick();

        // Read, no stalls
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_1234;
        tick();
        chk("rd_baddr", 256'(bus.burst_address), 256'(32'h0000_1220));
        read_beats("rd", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        chk("rd_resp",  256'(bus.pmem_resp),  256'(1));
        chk("rd_bread_off", 256'(bus.burst_read), 256'(0));
        chk("rd_rdata", bus.pmem_rdata_256,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        bus.pmem_read = 1'b0;
        tick();
        chk("rd_resp_once", 256'(bus.pmem_resp), 256'(0));
        chk("rd_rdata_hold", bus.pmem_rdata_256,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write with stalls
        s[0] = 64'hDEAD_BEEF_0000_0000;
        s[1] = 64'hDEAD_BEEF_1111_1111;
        s[2] = 64'hDEAD_BEEF_2222_2222;
        s[3] = 64'hDEAD_BEEF_3333_3333;
        wline = {s[3], s[2], s[1], s[0]};
        resp_pat  = 7'b1011001;  // bit k = burst_resp on step k: 1,0,0,1,1,0,1
        slice_pat = '{0, 1, 1, 1, 2, 3, 3};
        bus.pmem_write     = 1'b1;
        bus.pmem_address   = 32'h0000_5A7F;
        bus.pmem_wdata_256 = wline;
        tick();
        bus.pmem_wdata_256 = '1;
        chk("wr_baddr", 256'(bus.burst_address), 256'(32'h0000_5A60));
        for (int k = 0; k < 7; k++) begin
            chk("wr_bwrite_on", 256'(bus.burst_write), 256'(1));
            chk("wr_no_bread",  256'(bus.burst_read),  256'(0));
            chk("wr_no_resp",   256'(bus.pmem_resp),   256'(0));
            chk("wr_wdata",     256'(bus.burst_wdata), 256'(s[slice_pat[k]]));
            bus.burst_resp = resp_pat[k];
            tick();
        end
        bus.burst_resp = 1'b0;
        chk("wr_resp",       256'(bus.pmem_resp),   256'(1));
        chk("wr_bwrite_off", 256'(bus.burst_write), 256'(0));

        // Back-to-back: read issued the cycle after pmem_resp
        bus.pmem_write = 1'b0;
        tick();
        chk_idle_outputs("b2b_gap",
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_2040;
        tick();
        chk("b2b_baddr", 256'(bus.burst_address), 256'(32'h0000_2040));
        read_beats("b2b", 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                   64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404);
        chk("b2b_resp", 256'(bus.pmem_resp), 256'(1));
        chk("b2b_rdata", bus.pmem_rdata_256,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
        bus.pmem_read = 1'b0;
        tick();

        // Simultaneous read and write: read wins
        bus.pmem_read      = 1'b1;
        bus.pmem_write     = 1'b1;
        bus.pmem_address   = 32'h0000_0080;
        bus.pmem_wdata_256 = {4{64'hFFFF_0000_FFFF_0000}};
        tick();
        chk("both_baddr", 256'(bus.burst_address), 256'(32'h0000_0080));
        read_beats("both", 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        chk("both_resp", 256'(bus.pmem_resp), 256'(1));
        chk("both_rdata", bus.pmem_rdata_256,
            {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        tick();
        chk("both_no_write_after", 256'(bus.burst_write), 256'(0));

        // Reset mid-read after two accepted beats
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_0300;
        tick();
        bus.pmem_read   = 1'b0;
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = 64'h9999_9999_9999_9999;
        tick();
        bus.burst_rdata = 64'h9898_9898_9898_9898;
        tick();
        bus.burst_resp  = 1'b0;
        rst = 1'b1;
        tick();
        chk_idle_outputs("rst_mid", 256'(0));
        chk("rst_mid_baddr", 256'(bus.burst_address), 256'(0));
        rst = 1'b0;
        tick();
        chk("rst_mid_no_resp", 256'(bus.pmem_resp), 256'(0));

        // Fresh read from 0x40 after the abort
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_0040;
        tick();
        bus.pmem_read = 1'b0;
        chk("post_rst_baddr", 256'(bus.burst_address), 256'(32'h0000_0040));
        read_beats("post_rst", 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                   64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD);
        chk("post_rst_resp", 256'(bus.pmem_resp), 256'(1));
        chk("post_rst_rdata", bus.pmem_rdata_256,
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        tick();

        // burst_resp pulses while idle are ignored
        for (int i = 0; i < 3; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0 + 64'(i);
            tick();
            chk_idle_outputs("idle_resp",
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        end
        bus.burst_resp = 1'b0;
        tick();
        chk_idle_outputs("idle_after",
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bus exclusivity and address alignment hold on every cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(bus.burst_read && bus.burst_write) && (bus.burst_address[4:0] == 5'd0)) else begin
                errors++;
                $error("FAIL bus_excl observed rd=%0b wr=%0b addr=%0h expected exclusive aligned",
                       bus.burst_read, bus.burst_write, bus.burst_address);
            end
        end
    end
endmodule
